// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the up/down counter command stage: FSM encodings and direction codes.
package updown_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_AUTO_UP   = 2'd1,
      ST_AUTO_DOWN = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and rising-edge detect.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_r;
   logic          sync_r;
   logic          stable_r;
   logic          stable_d_r;
   logic [CW-1:0] cnt_r;

   // Two-flop synchronizer for the raw asynchronous button
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= btn_raw;
         sync_r <= meta_r;
      end
   end

   // Stability counter: the accepted level only flips after DEBOUNCE_CYCLES mismatching samples in a row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r      <= {CW{1'b0}};
         stable_r   <= 1'b0;
         stable_d_r <= 1'b0;
      end else begin
         stable_d_r <= stable_r;
         if (sync_r == stable_r) begin
            cnt_r <= {CW{1'b0}};
         end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= {CW{1'b0}};
            stable_r <= sync_r;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign level = stable_r;
   assign rise  = stable_r & ~stable_d_r;

endmodule

// File: rtl/updown_ctrl.sv
// Command stage for an up/down counter: debounced manual stepping with saturation,
// or an automatic ping-pong between 0 and the counter maximum.
module updown_ctrl
   import updown_ctrl_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_DIV        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             auto_mode,
   input  logic [WIDTH-1:0] count_in,
   output logic             enable,
   output logic             up_down
);

   localparam int PW = $clog2(AUTO_DIV);
   localparam logic [PW-1:0]    PRE_LAST = PW'(AUTO_DIV - 1);
   localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};

   logic          up_level_s, up_rise_s;
   logic          dn_level_s, dn_rise_s;
   logic          up_req_s, dn_req_s;
   logic          at_max_s, at_zero_s, step_s;
   logic          auto_meta_r, auto_sync_r;
   state_t        state_r, state_next_s;
   logic [PW-1:0] pre_r, pre_next_s;
   logic          enable_r, enable_next_s;
   logic          up_down_r, up_down_next_s;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_up),
      .level   (up_level_s),
      .rise    (up_rise_s)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_down),
      .level   (dn_level_s),
      .rise    (dn_rise_s)
   );

   assign up_req_s  = up_rise_s & up_level_s;
   assign dn_req_s  = dn_rise_s & dn_level_s;
   assign at_max_s  = (count_in == MAX_VAL);
   assign at_zero_s = (count_in == MIN_VAL);
   assign step_s    = (pre_r == PRE_LAST);

   // Two-flop synchronizer for the mode switch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         auto_meta_r <= 1'b0;
         auto_sync_r <= 1'b0;
      end else begin
         auto_meta_r <= auto_mode;
         auto_sync_r <= auto_meta_r;
      end
   end

   // Next-state, prescaler and strobe decisions
   always_comb begin
      state_next_s   = state_r;
      pre_next_s     = pre_r;
      enable_next_s  = 1'b0;
      up_down_next_s = up_down_r;
      case (state_r)
         ST_IDLE: begin
            // A request landing on a strobe cycle is dropped so count_in has settled before the next decision
            if (auto_sync_r) begin
               state_next_s = ST_AUTO_UP;
               pre_next_s   = {PW{1'b0}};
            end else if (up_req_s && !dn_req_s && !at_max_s && !enable_r) begin
               enable_next_s  = 1'b1;
               up_down_next_s = DIR_UP;
            end else if (dn_req_s && !up_req_s && !at_zero_s && !enable_r) begin
               enable_next_s  = 1'b1;
               up_down_next_s = DIR_DOWN;
            end else begin
               pre_next_s = {PW{1'b0}};
            end
         end
         ST_AUTO_UP: begin
            if (!auto_sync_r) begin
               state_next_s = ST_IDLE;
               pre_next_s   = {PW{1'b0}};
            end else if (step_s) begin
               pre_next_s    = {PW{1'b0}};
               enable_next_s = 1'b1;
               if (at_max_s) begin
                  state_next_s   = ST_AUTO_DOWN;
                  up_down_next_s = DIR_DOWN;
               end else begin
                  up_down_next_s = DIR_UP;
               end
            end else begin
               pre_next_s = pre_r + PW'(1);
            end
         end
         ST_AUTO_DOWN: begin
            if (!auto_sync_r) begin
               state_next_s = ST_IDLE;
               pre_next_s   = {PW{1'b0}};
            end else if (step_s) begin
               pre_next_s    = {PW{1'b0}};
               enable_next_s = 1'b1;
               if (at_zero_s) begin
                  state_next_s   = ST_AUTO_UP;
                  up_down_next_s = DIR_UP;
               end else begin
                  up_down_next_s = DIR_DOWN;
               end
            end else begin
               pre_next_s = pre_r + PW'(1);
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            pre_next_s   = {PW{1'b0}};
         end
      endcase
   end

   // State, prescaler and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pre_r     <= {PW{1'b0}};
         enable_r  <= 1'b0;
         up_down_r <= DIR_UP;
      end else begin
         state_r   <= state_next_s;
         pre_r     <= pre_next_s;
         enable_r  <= enable_next_s;
         up_down_r <= up_down_next_s;
      end
   end

   assign enable  = enable_r;
   assign up_down = up_down_r;

endmodule

// File: tb/tb_updown_ctrl.sv
// Scoreboard bench for updown_ctrl driving a behavioural 4-bit up/down counter fed back into count_in.
module tb_updown_ctrl;

   localparam int W  = 4;
   localparam int DB = 4;
   localparam int AD = 4;
   localparam int LAT = DB + 3;   // raw edge 0 is one edge after the driving negedge

   typedef struct {
      logic         dir;
      logic [W-1:0] cnt;
      int           at_edge;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         btn_up = 1'b0;
   logic         btn_down = 1'b0;
   logic         auto_mode = 1'b0;
   logic [W-1:0] cnt_r;
   logic         enable;
   logic         up_down;

   exp_t         sb_q[$];
   int           edge_cnt = 0;
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_count = 4'd0;

   updown_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .AUTO_DIV(AD)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .auto_mode (auto_mode),
      .count_in  (cnt_r),
      .enable    (enable),
      .up_down   (up_down)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(posedge clk or posedge rst) begin
      if (rst)
         cnt_r <= 4'd0;
      else if (enable)
         cnt_r <= up_down ? cnt_r + 4'd1 : cnt_r - 4'd1;
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && enable) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got enable=1 at edge %0d expected no strobe", edge_cnt);
         end else begin
            e = sb_q.pop_front();
            check("strobe_dir", int'(up_down), int'(e.dir));
            check("strobe_count", int'(cnt_r), int'(e.cnt));
            check("strobe_edge", edge_cnt, e.at_edge);
         end
      end
   end

   // Called at a negedge; holds the buttons for 'hold' edges, then idles long enough to re-debounce
   task automatic press(input logic up, input logic dn, input int hold, input logic expect_strobe);
      exp_t e;
      if (expect_strobe) begin
         e.dir     = up;
         e.cnt     = exp_count;
         e.at_edge = edge_cnt + LAT;
         sb_q.push_back(e);
         exp_count = up ? exp_count + 4'd1 : exp_count - 4'd1;
      end
      btn_up   = up;
      btn_down = dn;
      repeat (hold) @(negedge clk);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_count = 4'd0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      exp_t         e;
      int           t;
      int           guard;
      logic [W-1:0] seq [5];
      seq[0] = 4'd13; seq[1] = 4'd14; seq[2] = 4'd15; seq[3] = 4'd14; seq[4] = 4'd13;

      repeat (3) @(negedge clk);
      check("reset_enable", int'(enable), 0);
      check("reset_up_down", int'(up_down), 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Latency: one strobe exactly at raw edge 6
      press(1'b1, 1'b0, 10, 1'b1);
      check("latency_count", int'(cnt_r), int'(exp_count));

      // Reset asserted during a down strobe
      e.dir = 1'b0; e.cnt = exp_count; e.at_edge = edge_cnt + LAT;
      sb_q.push_back(e);
      btn_down = 1'b1;
      guard = 0;
      while (edge_cnt < e.at_edge && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("wait_strobe_bound", int'(guard < 100), 1);
      #2 rst = 1'b1;
      #1;
      check("midreset_enable", int'(enable), 0);
      check("midreset_up_down", int'(up_down), 1);
      btn_down = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_count = 4'd0;
      repeat (15) @(negedge clk);
      check("post_reset_count", int'(cnt_r), 0);

      // Short pulse must be rejected
      press(1'b1, 1'b0, 3, 1'b0);
      check("short_pulse_count", int'(cnt_r), 0);

      // Manual stepping
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 6, 1'b1);
      check("three_up_count", int'(cnt_r), 3);
      press(1'b0, 1'b1, 6, 1'b1);
      check("down_count", int'(cnt_r), 2);
      check("down_up_down_held", int'(up_down), 0);
      press(1'b1, 1'b1, 6, 1'b0);
      check("both_count", int'(cnt_r), 2);

      // Saturation at the top
      do_reset();
      for (int i = 0; i < 16; i++) press(1'b1, 1'b0, 6, i < 15);
      check("sat_max_count", int'(cnt_r), 15);

      // Saturation at the bottom
      do_reset();
      press(1'b0, 1'b1, 6, 1'b0);
      check("sat_zero_count", int'(cnt_r), 0);

      // Climb to 13, then auto ping-pong with buttons toggling throughout
      for (int i = 0; i < 13; i++) press(1'b1, 1'b0, 6, 1'b1);
      check("pre_auto_count", int'(cnt_r), 13);
      t = edge_cnt;
      auto_mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         e.dir = (k < 2);
         e.cnt = seq[k];
         e.at_edge = t + 7 + AD * k;
         sb_q.push_back(e);
      end
      for (int k = 1; k <= 23; k++) begin
         @(negedge clk);
         if (k == 5) btn_up = 1'b1;
         if (k == 6) btn_down = 1'b1;
         if (k == 15) begin
            btn_up = 1'b0;
            btn_down = 1'b0;
         end
      end
      auto_mode = 1'b0;
      repeat (20) @(negedge clk);
      check("auto_frozen_count", int'(cnt_r), 12);
      check("auto_pending", sb_q.size(), 0);
      exp_count = 4'd12;

      // Manual works again after leaving auto
      press(1'b1, 1'b0, 6, 1'b1);
      check("post_auto_count", int'(cnt_r), 13);
      check("final_pending", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
